// File: rtl/uart_tx_arb.sv
// uart_tx_arb: round-robin arbiter sharing one uart_tx between N byte requesters.
// Optional sticky ownership for multi-byte messages with UART_TX_ARB_LOCK_EN.
module uart_tx_arb #(
  parameter int N = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic [8*N-1:0] data_in,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   grant,
  output logic           tx_rdy,
  output logic [7:0]     tx_data,
  input  logic           tx_fetch,
  output logic           busy
`ifdef UART_TX_ARB_LOCK_EN
  ,
  input  logic [N-1:0]   lock
`endif
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  typedef enum logic [1:0] {IDLE, GRANT, HOLD} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d, pick;
  logic [N-1:0] grant_q, grant_d, ack_q, ack_d;
  logic tx_rdy_q, tx_rdy_d, busy_q, busy_d, found;
  logic [7:0] tx_data_q, tx_data_d;
  logic sel;
  int idx;
`ifdef UART_TX_ARB_LOCK_EN
  logic locked_q, locked_d;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= PW'(N - 1);
      grant_q   <= '0;
      ack_q     <= '0;
      tx_rdy_q  <= 1'b0;
      tx_data_q <= 8'h00;
      busy_q    <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
      locked_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      tx_rdy_q  <= tx_rdy_d;
      tx_data_q <= tx_data_d;
      busy_q    <= busy_d;
`ifdef UART_TX_ARB_LOCK_EN
      locked_q  <= locked_d;
`endif
    end
  end
  // Winner scan starts just after the last owner and wraps modulo N.
  always_comb begin
    pick = ptr_q;
    sel = 1'b0;
    idx = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!sel && req[PW'(idx)]) begin
        sel = 1'b1;
        pick = PW'(idx);
      end
    end
    found = |req;
`ifdef UART_TX_ARB_LOCK_EN
    // ptr_q still names the lock owner, since a locked grant never advances it.
    pick = (locked_q && req[ptr_q]) ? ptr_q : pick;
`endif
  end
  always_comb begin
    state_d = (state_q == IDLE)  ? (found ? GRANT : IDLE) :
              (state_q == GRANT) ? (tx_fetch ? HOLD : GRANT) : IDLE;
  end
  always_comb begin
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = ack_q;
    tx_rdy_d  = tx_rdy_q;
    tx_data_d = tx_data_q;
    busy_d    = state_d != IDLE;
`ifdef UART_TX_ARB_LOCK_EN
    locked_d  = locked_q;
`endif
    if (state_q == IDLE && found) begin
      grant_d   = {{(N-1){1'b0}}, 1'b1} << pick;
      tx_data_d = data_in[{pick, 3'b000} +: 8];
      tx_rdy_d  = 1'b1;
      ptr_d     = pick;
    end
`ifdef UART_TX_ARB_LOCK_EN
    if (state_q == IDLE && locked_q && !req[ptr_q])
      locked_d = 1'b0;
    if (state_q == GRANT && tx_fetch)
      locked_d = lock[ptr_q];
`endif
    if (state_q == GRANT && tx_fetch) begin
      tx_rdy_d = 1'b0;
      ack_d    = grant_q;
    end
    if (state_q == HOLD) begin
      ack_d   = '0;
      grant_d = '0;
    end
  end
  assign ack     = ack_q;
  assign grant   = grant_q;
  assign tx_rdy  = tx_rdy_q;
  assign tx_data = tx_data_q;
  assign busy    = busy_q;
endmodule

// File: tb/tb_uart_tx_arb.sv
// tb_uart_tx_arb: vector table, corner sequences and randomized model check for uart_tx_arb.
module tb_uart_tx_arb;
  localparam int N = 3;
  localparam int DW = 8 * N;
  logic clk = 1'b0, rst = 1'b1, tx_fetch = 1'b0;
  logic [N-1:0] req = '0, ack, grant;
  logic [DW-1:0] data_in = '0;
  logic tx_rdy, busy;
  logic [7:0] tx_data;
`ifdef UART_TX_ARB_LOCK_EN
  logic [N-1:0] lock = '0;
`endif
  int tests = 0, fails = 0;
  typedef struct {
    logic [N-1:0] req;
    logic         f;
    logic [N-1:0] eg, ea;
    logic         er;
    logic [7:0]   ed;
    logic         eb;
  } vec_t;
  vec_t tbl[13];
  int last, w;
  logic mb, mr;
  logic [N-1:0] mg, ma;
  logic [7:0] md;

  uart_tx_arb #(.N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack), .grant(grant),
    .tx_rdy(tx_rdy), .tx_data(tx_data), .tx_fetch(tx_fetch), .busy(busy)
`ifdef UART_TX_ARB_LOCK_EN
    , .lock(lock)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got %h exp %h", nm, got, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [N-1:0] eg, input logic [N-1:0] ea,
                         input logic er, input logic [7:0] ed, input logic eb);
    chk({nm, ".grant"}, 32'(grant), 32'(eg));
    chk({nm, ".ack"}, 32'(ack), 32'(ea));
    chk({nm, ".tx_rdy"}, 32'(tx_rdy), 32'(er));
    chk({nm, ".tx_data"}, 32'(tx_data), 32'(ed));
    chk({nm, ".busy"}, 32'(busy), 32'(eb));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    tx_fetch = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  function automatic int rr(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++)
      if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

`ifdef UART_TX_ARB_LOCK_EN
  task automatic lock_byte(input string nm, input logic [N-1:0] eg, input logic lk);
    tick();
    chk({nm, ".grant"}, 32'(grant), 32'(eg));
    lock = lk ? 3'b001 : 3'b000;
    tx_fetch = 1'b1;
    tick();
    chk({nm, ".ack"}, 32'(ack), 32'(eg));
    tx_fetch = 1'b0;
    tick();
    chk({nm, ".idle"}, 32'(busy), 32'd0);
  endtask
`endif

  initial begin
    tbl[0]  = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b1, 8'h11, 1'b1};
    tbl[1]  = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b0, 8'h11, 1'b1};
    tbl[2]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 8'h11, 1'b0};
    tbl[3]  = '{3'b111, 1'b0, 3'b010, 3'b000, 1'b1, 8'h22, 1'b1};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 3'b010, 1'b0, 8'h22, 1'b1};
    tbl[5]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 8'h22, 1'b0};
    tbl[6]  = '{3'b111, 1'b0, 3'b100, 3'b000, 1'b1, 8'h33, 1'b1};
    tbl[7]  = '{3'b111, 1'b1, 3'b100, 3'b100, 1'b0, 8'h33, 1'b1};
    tbl[8]  = '{3'b111, 1'b0, 3'b000, 3'b000, 1'b0, 8'h33, 1'b0};
    tbl[9]  = '{3'b111, 1'b0, 3'b001, 3'b000, 1'b1, 8'h11, 1'b1};
    tbl[10] = '{3'b111, 1'b1, 3'b001, 3'b001, 1'b0, 8'h11, 1'b1};
    tbl[11] = '{3'b000, 1'b0, 3'b000, 3'b000, 1'b0, 8'h11, 1'b0};
    tbl[12] = '{3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 8'h11, 1'b0};

    do_reset();
    chk_all("reset", '0, '0, 1'b0, 8'h00, 1'b0);
    data_in = {8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 13; i++) begin
      req = tbl[i].req;
      tx_fetch = tbl[i].f;
      tick();
      chk_all($sformatf("vec%0d", i), tbl[i].eg, tbl[i].ea, tbl[i].er, tbl[i].ed, tbl[i].eb);
    end
    tx_fetch = 1'b0;

    do_reset();
    req = 3'b010;
    data_in = {8'h00, 8'h3C, 8'h00};
    tick();
    chk_all("dchg.grant", 3'b010, '0, 1'b1, 8'h3C, 1'b1);
    data_in = {8'h00, 8'hFF, 8'h00};
    tick();
    chk("dchg.hold_data", 32'(tx_data), 32'h3C);
    tx_fetch = 1'b1;
    tick();
    chk_all("dchg.ack", 3'b010, 3'b010, 1'b0, 8'h3C, 1'b1);
    tx_fetch = 1'b0;
    req = '0;
    tick();
    chk_all("dchg.idle", '0, '0, 1'b0, 8'h3C, 1'b0);

    do_reset();
    req = 3'b001;
    data_in = {8'h00, 8'h00, 8'h5A};
    tick();
    chk("wd.grant", 32'(grant), 32'b001);
    req = '0;
    tick();
    chk_all("wd.held", 3'b001, '0, 1'b1, 8'h5A, 1'b1);
    tx_fetch = 1'b1;
    tick();
    chk("wd.ack", 32'(ack), 32'b001);
    tx_fetch = 1'b0;
    tick();
    tick();
    chk_all("wd.nogrant", '0, '0, 1'b0, 8'h5A, 1'b0);

    do_reset();
    req = 3'b110;
    data_in = {8'h33, 8'h22, 8'h11};
    tick();
    chk("rst.pre", 32'(grant), 32'b010);
    #2 rst = 1'b1;
    #1 chk_all("rst.async", '0, '0, 1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    req = 3'b111;
    tick();
    chk_all("rst.first", 3'b001, '0, 1'b1, 8'h11, 1'b1);

`ifdef UART_TX_ARB_LOCK_EN
    do_reset();
    req = 3'b011;
    data_in = {8'h33, 8'h22, 8'h11};
    lock_byte("lk1", 3'b001, 1'b1);
    lock_byte("lk2", 3'b001, 1'b1);
    lock_byte("lk3", 3'b001, 1'b0);
    lock_byte("lk4", 3'b010, 1'b0);
    lock = '0;
`endif

    do_reset();
    last = N - 1;
    mb = 1'b0; mr = 1'b0; mg = '0; ma = '0; md = 8'h00;
    for (int c = 0; c < 400; c++) begin
      req = N'($urandom_range(0, (1 << N) - 1));
      data_in = DW'($urandom());
      tx_fetch = ($urandom_range(0, 2) == 0);
      if (!mb) begin
        ma = '0;
        if (req != '0) begin
          w = rr(req, last);
          mg = N'(1) << w;
          md = 8'(data_in >> (8 * w));
          mr = 1'b1;
          mb = 1'b1;
          last = w;
        end
      end else if (mr) begin
        if (tx_fetch) begin
          mr = 1'b0;
          ma = mg;
        end
      end else begin
        ma = '0;
        mg = '0;
        mb = 1'b0;
      end
      tick();
      chk_all($sformatf("rand%0d", c), mg, ma, mr, md, mb);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter that shares one uart_tx transmitter between N byte-stream requesters.
- Drives the transmitter's data_rdy and data[8] inputs and consumes its fetch pulse.
- Keeps the latched byte stable through the transmitter's latch cycle, and returns a one-cycle ack to the requester whose byte was taken.
- Sits between client FSMs (debug console, status reporter, etc.) and a single uart_tx on the same clk.

Parameters:
N, 2, number of requesters (legal range 2..8).

Ports:
clk  input  1  transmitter clock; the same clock drives the attached uart_tx.
rst  input  1  reset; asynchronous and active-high.
req  input  N  per-requester level request; the byte is on data_in while high.
data_in  input  8*N  requester i byte at bits [8i+7:8i]; must be stable while req[i]=1 and until grant[i] is high.
ack  output  N  one-cycle pulse to the requester whose byte the transmitter fetched.
grant  output  N  one-hot owner of the transmitter; all zero when idle.
tx_rdy  output  1  to uart_tx data_rdy.
tx_data  output  8  to uart_tx data[8].
tx_fetch  input  1  from uart_tx fetch.
busy  output  1  high in every state except IDLE.
lock  input  N  present only with UART_TX_ARB_LOCK_EN; see Optional Feature.

Behaviour:
- Async reset values:
  - State = IDLE.
  - grant = 0, ack = 0, tx_rdy = 0, tx_data = 8'h00, busy = 0.
  - Round-robin pointer = N-1, so requester 0 has first priority.
- All outputs are registered.
- States:
  - IDLE:
    - If req != 0, pick the first set req[i] scanning upward from pointer+1 (mod N).
    - Then: grant[i] <= 1; tx_data <= data_in[i]; tx_rdy <= 1; pointer <= i; go to GRANT.
    - If req = 0, stay in IDLE.
  - GRANT:
    - Hold tx_rdy = 1 and keep tx_data constant.
    - On tx_fetch = 1: tx_rdy <= 0; ack[i] <= 1; go to HOLD.
    - With tx_fetch = 0, GRANT is held indefinitely; there is no timeout.
  - HOLD:
    - One cycle; ack[i] = 1.
    - tx_data stays unchanged, because uart_tx latches it in this cycle.
    - Next: ack <= 0; grant <= 0; go to IDLE.
- Latency:
  - From req sampled high in IDLE to tx_rdy high: 1 cycle.
  - From tx_fetch to ack: 1 cycle.
  - Minimum byte-to-byte spacing at the arbiter is 3 cycles; the actual rate is set by the uart_tx frame (10 clk).
- Byte capture: the byte is captured at the IDLE to GRANT edge. Later changes to data_in[i] are ignored for that byte.
- Requester rules:
  - Keep req high and data stable until the grant edge.
  - After ack, present the next byte or drop req by the following edge.
- req[i] dropped while granted: the captured byte is still sent and ack[i] still pulses. The arbiter does not abort.
- Simultaneous requests: resolved purely by the round-robin order. Two or more continuously requesting clients alternate strictly.
- tx_fetch seen in IDLE or HOLD: ignored (protocol error, no state change).
- Reset mid-operation:
  - The arbiter returns to IDLE immediately and no ack is issued.
  - uart_tx has no reset and may still finish a frame already started. That is acceptable, because tx_rdy = 0 prevents a further start.
- Width: the pointer is ceil(log2(N)) bits, and the scan wraps modulo N.

Optional Feature:
Macro: UART_TX_ARB_LOCK_EN
- With the macro defined:
  - The lock[N] port exists.
  - If lock[i] = 1 when tx_fetch is seen in GRANT, the arbiter records owner = i.
  - In the next IDLE, if req[owner] = 1, owner is granted regardless of round-robin order. The pointer is not advanced.
  - The lock is released when the owner's req is low in IDLE, or when lock[owner] = 0 at its next fetch. Round-robin then resumes from the owner.
  - Reset clears the lock.
  - Purpose: multi-byte messages are not interleaved.
- Without the macro: the lock port is absent and arbitration is pure round-robin.

Test Plan:
- Single requester: N=2, req[0]=1, data_in[0]=8'hA5, uart_tx attached -> grant=2'b01 one cycle later, out emits frame 0,1,0,1,0,0,1,0,1,1 (LSB first), ack[0] one pulse, busy low after HOLD.
- Contention: N=3, all req held high with bytes 8'h11, 8'h22, 8'h33 -> transmitted order 11,22,33,11,... with grant one-hot every time and exactly one ack per byte.
- Data change after grant: req[1]=1 with 8'h3C, then data_in[1] changes to 8'hFF one cycle after grant -> 8'h3C is sent.
- Request withdrawn: req[0] drops in the GRANT state before fetch -> the byte is still sent, ack[0] pulses, the arbiter returns to IDLE and issues no second grant to requester 0.
- Reset mid-GRANT: assert rst asynchronously -> grant, tx_rdy, ack and busy are 0 immediately, and after release requester 0 wins first.
- UART_TX_ARB_LOCK_EN: req[0] and req[1] high, lock[0]=1 for 3 bytes -> the three requester-0 bytes are sent back-to-back, then the requester-1 byte.
